// File: rtl/cpu_cycle_sequencer_if.sv
// Bundle of fetch port, data-memory port and datapath control signals
// between the cycle sequencer (master) and the datapath/memories (slave).
interface cpu_cycle_sequencer_if;
  // instruction fetch port
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  // data memory port
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  // datapath controls and status
  logic        alu_zero;
  logic        reg2loc;
  logic        alu_src;
  logic        mem_to_reg;
  logic        reg_write;
  logic [3:0]  alu_op;
  logic [1:0]  num_rx;
  logic [1:0]  num_ry;
  logic [1:0]  num_rz;
  logic [3:0]  imm;
  logic [3:0]  pc;
  logic [2:0]  state;
  logic        halted;
  logic        error;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
           reg2loc, alu_src, mem_to_reg, reg_write, alu_op,
           num_rx, num_ry, num_rz, imm, pc, state, halted, error,
    input  imem_ack, imem_data, dmem_ack, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
           reg2loc, alu_src, mem_to_reg, reg_write, alu_op,
           num_rx, num_ry, num_rz, imm, pc, state, halted, error,
    output imem_ack, imem_data, dmem_ack, alu_zero
  );
endinterface

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle controller for the 4-bit CPU: fetches a 16-bit instruction over
// a req/ack port, decodes it once, then steps the datapath through
// EXEC / MEM / WB with registered controls. Owns the PC and halts on either
// the halt opcode or an acknowledge timeout.
module cpu_cycle_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 8,        // 1..15
  parameter logic [3:0]  PC_RESET    = 4'h0,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  cpu_cycle_sequencer_if.master io_bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(ACK_TIMEOUT);
  localparam logic [3:0] OP_B       = 4'b1010;
  localparam logic [3:0] OP_BZ      = 4'b1011;
  localparam logic [3:0] OP_ADDI    = 4'b0111;
  localparam logic [3:0] OP_STUR    = 4'b1000;
  localparam logic [3:0] OP_LDUR    = 4'b1001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_instr;
  logic [3:0]  r_pc;
  logic [3:0]  r_cnt;
  logic        r_error;
  logic        r_zero;

  // controls captured in DECODE and held until the next DECODE
  logic        r_reg2loc, r_alu_src, r_mem_to_reg;
  logic [3:0]  r_alu_op;
  logic [1:0]  r_num_rx, r_num_ry, r_num_rz;
  logic [3:0]  r_imm;
  logic        r_writes, r_is_mem, r_is_store, r_is_branch, r_is_bz;

  // decode of the latched instruction
  logic [3:0]  w_opcode;
  logic        w_dec_reg2loc, w_dec_alu_src, w_dec_mem_to_reg;
  logic [3:0]  w_dec_alu_op;
  logic [1:0]  w_dec_num_ry;
  logic        w_dec_writes, w_dec_is_mem, w_dec_is_store;
  logic        w_dec_is_branch, w_dec_is_bz;

  logic        w_wait;
  logic [3:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_take;
  logic [3:0]  w_pc_next;

  assign w_opcode  = r_instr[15:12];

  // a wait cycle is a cycle with the current port's req high and no ack;
  // the other port's ack is never looked at
  assign w_wait    = ((r_state == S_FETCH) && !io_bus.imem_ack) ||
                     ((r_state == S_MEM)   && !io_bus.dmem_ack);
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_timeout = w_wait && (w_cnt_inc == LP_TIMEOUT);

  // branch target arithmetic is 4-bit and wraps modulo 16 by construction
  assign w_take    = r_is_branch || (r_is_bz && r_zero);
  assign w_pc_next = w_take ? (r_pc + r_imm) : (r_pc + 4'd1);

  // state register
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_state_next;
  end

  // next-state logic
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // variable unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (io_bus.imem_ack) w_state_next = S_DECODE;
        else if (w_timeout)  w_state_next = S_HALT;
      end
      S_DECODE: w_state_next = (w_opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
      S_EXEC:   w_state_next = r_is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (io_bus.dmem_ack) w_state_next = S_WB;
        else if (w_timeout)  w_state_next = S_HALT;
      end
      S_WB:     w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // output strobes, derived purely from the registered state and controls
  always_comb begin
    io_bus.imem_req  = (r_state == S_FETCH);
    io_bus.dmem_req  = (r_state == S_MEM);
    io_bus.dmem_we   = (r_state == S_MEM) && r_is_store;
    io_bus.reg_write = (r_state == S_WB)  && r_writes;
    io_bus.halted    = (r_state == S_HALT);
  end

  // instruction decode table for the latched instruction word
  always_comb begin
    w_dec_reg2loc    = 1'b0;
    w_dec_alu_src    = 1'b0;
    w_dec_mem_to_reg = 1'b0;
    w_dec_alu_op     = 4'd0;
    w_dec_writes     = 1'b0;
    w_dec_is_mem     = 1'b0;
    w_dec_is_store   = 1'b0;
    w_dec_is_branch  = 1'b0;
    w_dec_is_bz      = 1'b0;
    case (w_opcode)
      OP_B:    w_dec_is_branch = 1'b1;
      OP_BZ: begin
        w_dec_reg2loc = 1'b1;
        w_dec_alu_op  = ALU_ADD;
        w_dec_is_bz   = 1'b1;
      end
      OP_ADDI: begin
        w_dec_alu_src = 1'b1;
        w_dec_alu_op  = ALU_ADD;
        w_dec_writes  = 1'b1;
      end
      OP_STUR: begin
        w_dec_reg2loc  = 1'b1;
        w_dec_alu_src  = 1'b1;
        w_dec_alu_op   = ALU_ADD;
        w_dec_is_mem   = 1'b1;
        w_dec_is_store = 1'b1;
      end
      OP_LDUR: begin
        w_dec_alu_src    = 1'b1;
        w_dec_mem_to_reg = 1'b1;
        w_dec_alu_op     = ALU_ADD;
        w_dec_writes     = 1'b1;
        w_dec_is_mem     = 1'b1;
      end
      default: begin
        // R-type: the opcode is the ALU operation
        w_dec_alu_op = w_opcode;
        w_dec_writes = 1'b1;
      end
    endcase
    w_dec_num_ry = w_dec_reg2loc ? r_instr[5:4] : r_instr[1:0];
  end

  // instruction register, controls, PC, timeout counter and sticky error
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_instr      <= 16'd0;
      r_pc         <= PC_RESET;
      r_cnt        <= 4'd0;
      r_error      <= 1'b0;
      r_zero       <= 1'b0;
      r_reg2loc    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_op     <= 4'd0;
      r_num_rx     <= 2'd0;
      r_num_ry     <= 2'd0;
      r_num_rz     <= 2'd0;
      r_imm        <= 4'd0;
      r_writes     <= 1'b0;
      r_is_mem     <= 1'b0;
      r_is_store   <= 1'b0;
      r_is_branch  <= 1'b0;
      r_is_bz      <= 1'b0;
    end else begin
      r_cnt <= w_wait ? w_cnt_inc : 4'd0;
      if (w_timeout) r_error <= 1'b1;
      case (r_state)
        S_FETCH: if (io_bus.imem_ack) r_instr <= io_bus.imem_data;
        S_DECODE: begin
          // a halting instruction leaves the previous controls untouched
          if (w_opcode != HALT_OPCODE) begin
            r_reg2loc    <= w_dec_reg2loc;
            r_alu_src    <= w_dec_alu_src;
            r_mem_to_reg <= w_dec_mem_to_reg;
            r_alu_op     <= w_dec_alu_op;
            r_num_rx     <= r_instr[3:2];
            r_num_ry     <= w_dec_num_ry;
            r_num_rz     <= r_instr[5:4];
            r_imm        <= r_instr[11:8];
            r_writes     <= w_dec_writes;
            r_is_mem     <= w_dec_is_mem;
            r_is_store   <= w_dec_is_store;
            r_is_branch  <= w_dec_is_branch;
            r_is_bz      <= w_dec_is_bz;
          end
        end
        S_EXEC:  r_zero <= io_bus.alu_zero;
        S_WB:    r_pc   <= w_pc_next;
        default: ;
      endcase
    end
  end

  assign io_bus.imem_addr  = r_pc;
  assign io_bus.pc         = r_pc;
  assign io_bus.state      = r_state;
  assign io_bus.error      = r_error;
  assign io_bus.reg2loc    = r_reg2loc;
  assign io_bus.alu_src    = r_alu_src;
  assign io_bus.mem_to_reg = r_mem_to_reg;
  assign io_bus.alu_op     = r_alu_op;
  assign io_bus.num_rx     = r_num_rx;
  assign io_bus.num_ry     = r_num_ry;
  assign io_bus.num_rz     = r_num_rz;
  assign io_bus.imm        = r_imm;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer: each scenario task drives the
// fetch/data ports and compares outputs against hand-computed values.
module tb_cpu_cycle_sequencer;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  cpu_cycle_sequencer_if bus ();

  cpu_cycle_sequencer #(
    .ACK_TIMEOUT (8),
    .PC_RESET    (4'h0),
    .HALT_OPCODE (4'b1111)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // advance one clock; inputs changed and outputs sampled 1 time unit after the edge
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst           = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.dmem_ack  = 1'b0;
    bus.alu_zero  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // one non-memory instruction with zero-wait fetch ack: FETCH, DECODE, EXEC, WB
  task automatic run_simple(input logic [15:0] data, input logic zero,
                            output logic wb_rw, output logic [2:0] wb_state);
    bus.imem_data = data;
    bus.imem_ack  = 1'b1;
    bus.alu_zero  = zero;
    step();
    bus.imem_ack  = 1'b0;
    step();
    step();
    wb_rw    = bus.reg_write;
    wb_state = bus.state;
    step();
    bus.alu_zero  = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++; if (bus.state !== 3'd0)    begin n_bad++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    n_vec++; if (bus.pc !== 4'h0)       begin n_bad++; $display("FAIL reset_pc got %0h exp 0", bus.pc); end
    n_vec++; if (bus.error !== 1'b0)    begin n_bad++; $display("FAIL reset_error got %b exp 0", bus.error); end
    n_vec++; if (bus.halted !== 1'b0)   begin n_bad++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
    n_vec++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_dmem_req got %b exp 0", bus.dmem_req); end
    n_vec++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got %b exp 0", bus.reg_write); end
    n_vec++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_imem_req got %b exp 1", bus.imem_req); end
  endtask

  task automatic test_addi;
    bus.imem_data = 16'h7320;
    bus.imem_ack  = 1'b1;
    step();
    n_vec++; if (bus.state !== 3'd1)    begin n_bad++; $display("FAIL addi_decode_state got %0d exp 1", bus.state); end
    n_vec++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL addi_req_after_ack got %b exp 0", bus.imem_req); end
    bus.imem_ack = 1'b0;
    step();
    n_vec++; if (bus.alu_src !== 1'b1)  begin n_bad++; $display("FAIL addi_alu_src got %b exp 1", bus.alu_src); end
    n_vec++; if (bus.imm !== 4'd3)      begin n_bad++; $display("FAIL addi_imm got %0h exp 3", bus.imm); end
    n_vec++; if (bus.num_rz !== 2'd2)   begin n_bad++; $display("FAIL addi_num_rz got %0d exp 2", bus.num_rz); end
    n_vec++; if (bus.alu_op !== 4'd2)   begin n_bad++; $display("FAIL addi_alu_op got %0h exp 2", bus.alu_op); end
    n_vec++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL addi_rw_exec got %b exp 0", bus.reg_write); end
    step();
    n_vec++; if (bus.state !== 3'd4)    begin n_bad++; $display("FAIL addi_wb_state got %0d exp 4", bus.state); end
    n_vec++; if (bus.reg_write !== 1'b1) begin n_bad++; $display("FAIL addi_rw_wb got %b exp 1", bus.reg_write); end
    step();
    n_vec++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL addi_rw_after got %b exp 0", bus.reg_write); end
    n_vec++; if (bus.pc !== 4'd1)       begin n_bad++; $display("FAIL addi_pc got %0h exp 1", bus.pc); end
    n_vec++; if (bus.imem_addr !== 4'd1) begin n_bad++; $display("FAIL addi_imem_addr got %0h exp 1", bus.imem_addr); end
  endtask

  task automatic test_branch;
    logic       rw;
    logic [2:0] st;
    run_simple(16'hAD00, 1'b0, rw, st);           // B +13 at pc 1
    n_vec++; if (bus.pc !== 4'd14) begin n_bad++; $display("FAIL b_pc got %0h exp e", bus.pc); end
    n_vec++; if (rw !== 1'b0)      begin n_bad++; $display("FAIL b_no_write got %b exp 0", rw); end
    run_simple(16'hB500, 1'b1, rw, st);           // BZ +5, taken, wraps
    n_vec++; if (bus.pc !== 4'd3)  begin n_bad++; $display("FAIL bz_taken_wrap_pc got %0h exp 3", bus.pc); end
    n_vec++; if (st !== 3'd4)      begin n_bad++; $display("FAIL bz_wb_state got %0d exp 4", st); end
    run_simple(16'hAB00, 1'b0, rw, st);           // B +11 at pc 3
    n_vec++; if (bus.pc !== 4'd14) begin n_bad++; $display("FAIL b2_pc got %0h exp e", bus.pc); end
    run_simple(16'hB500, 1'b0, rw, st);           // BZ not taken
    n_vec++; if (bus.pc !== 4'd15) begin n_bad++; $display("FAIL bz_not_taken_pc got %0h exp f", bus.pc); end
    n_vec++; if (bus.reg2loc !== 1'b1) begin n_bad++; $display("FAIL bz_reg2loc got %b exp 1", bus.reg2loc); end
    n_vec++; if (bus.alu_op !== 4'd2)  begin n_bad++; $display("FAIL bz_alu_op got %0h exp 2", bus.alu_op); end
  endtask

  task automatic test_ldur;
    int n;
    bus.imem_data = 16'h9214;
    bus.imem_ack  = 1'b1;
    step();
    bus.imem_ack  = 1'b0;
    step();
    n_vec++; if (bus.mem_to_reg !== 1'b1) begin n_bad++; $display("FAIL ldur_mem_to_reg got %b exp 1", bus.mem_to_reg); end
    n_vec++; if (bus.num_rx !== 2'd1)     begin n_bad++; $display("FAIL ldur_num_rx got %0d exp 1", bus.num_rx); end
    n_vec++; if (bus.num_ry !== 2'd0)     begin n_bad++; $display("FAIL ldur_num_ry got %0d exp 0", bus.num_ry); end
    step();
    n_vec++; if (bus.dmem_req !== 1'b1)   begin n_bad++; $display("FAIL ldur_dmem_req got %b exp 1", bus.dmem_req); end
    n_vec++; if (bus.dmem_we !== 1'b0)    begin n_bad++; $display("FAIL ldur_dmem_we got %b exp 0", bus.dmem_we); end
    n = 0;
    while (bus.dmem_req === 1'b1 && n < 10) begin
      n++;
      if (n == 3) bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
    end
    n_vec++; if (n != 3)                  begin n_bad++; $display("FAIL ldur_req_cycles got %0d exp 3", n); end
    n_vec++; if (bus.reg_write !== 1'b1)  begin n_bad++; $display("FAIL ldur_rw_wb got %b exp 1", bus.reg_write); end
    step();
    n_vec++; if (bus.pc !== 4'd0)         begin n_bad++; $display("FAIL ldur_pc_wrap got %0h exp 0", bus.pc); end
    n_vec++; if (bus.reg_write !== 1'b0)  begin n_bad++; $display("FAIL ldur_rw_after got %b exp 0", bus.reg_write); end
  endtask

  task automatic test_back_to_back;
    logic       rw;
    logic [2:0] st;
    run_simple(16'h3000, 1'b0, rw, st);
    n_vec++; if (rw !== 1'b1)         begin n_bad++; $display("FAIL r1_write got %b exp 1", rw); end
    n_vec++; if (bus.alu_op !== 4'd3) begin n_bad++; $display("FAIL r1_alu_op got %0h exp 3", bus.alu_op); end
    n_vec++; if (bus.pc !== 4'd1)     begin n_bad++; $display("FAIL r1_pc got %0h exp 1", bus.pc); end
    bus.dmem_ack = 1'b1;                          // stray data ack, must be ignored
    run_simple(16'h5000, 1'b0, rw, st);
    bus.dmem_ack = 1'b0;
    n_vec++; if (bus.state !== 3'd0)  begin n_bad++; $display("FAIL r2_latency_state got %0d exp 0", bus.state); end
    n_vec++; if (bus.alu_op !== 4'd5) begin n_bad++; $display("FAIL r2_alu_op got %0h exp 5", bus.alu_op); end
    n_vec++; if (bus.pc !== 4'd2)     begin n_bad++; $display("FAIL r2_pc got %0h exp 2", bus.pc); end
  endtask

  task automatic test_stur_reset;
    bus.imem_data = 16'h8110;
    bus.imem_ack  = 1'b1;
    step();
    bus.imem_ack  = 1'b0;
    step();
    step();
    n_vec++; if (bus.dmem_req !== 1'b1) begin n_bad++; $display("FAIL stur_dmem_req got %b exp 1", bus.dmem_req); end
    n_vec++; if (bus.dmem_we !== 1'b1)  begin n_bad++; $display("FAIL stur_dmem_we got %b exp 1", bus.dmem_we); end
    bus.imem_ack = 1'b1;                          // wrong-port ack in MEM
    step();
    bus.imem_ack = 1'b0;
    n_vec++; if (bus.state !== 3'd3)    begin n_bad++; $display("FAIL stur_ignore_imem_ack got %0d exp 3", bus.state); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL stur_rst_dmem_req got %b exp 0", bus.dmem_req); end
    n_vec++; if (bus.pc !== 4'd0)       begin n_bad++; $display("FAIL stur_rst_pc got %0h exp 0", bus.pc); end
    n_vec++; if (bus.state !== 3'd0)    begin n_bad++; $display("FAIL stur_rst_state got %0d exp 0", bus.state); end
    n_vec++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL stur_rst_rw got %b exp 0", bus.reg_write); end
    n_vec++; if (bus.alu_src !== 1'b0)  begin n_bad++; $display("FAIL stur_rst_alu_src got %b exp 0", bus.alu_src); end
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    n = 0;
    while (bus.imem_req === 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_vec++; if (n != 8)                begin n_bad++; $display("FAIL timeout_cycles got %0d exp 8", n); end
    n_vec++; if (bus.state !== 3'd5)    begin n_bad++; $display("FAIL timeout_state got %0d exp 5", bus.state); end
    n_vec++; if (bus.error !== 1'b1)    begin n_bad++; $display("FAIL timeout_error got %b exp 1", bus.error); end
    n_vec++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_imem_req got %b exp 0", bus.imem_req); end
    do_reset();
    n_vec++; if (bus.error !== 1'b0)    begin n_bad++; $display("FAIL timeout_error_clear got %b exp 0", bus.error); end
  endtask

  task automatic test_halt;
    logic       rw;
    logic [2:0] st;
    run_simple(16'hA600, 1'b0, rw, st);           // B +6 from pc 0
    n_vec++; if (bus.pc !== 4'd6)       begin n_bad++; $display("FAIL halt_setup_pc got %0h exp 6", bus.pc); end
    bus.imem_data = 16'hF000;
    bus.imem_ack  = 1'b1;
    step();
    bus.imem_ack  = 1'b0;
    step();
    n_vec++; if (bus.state !== 3'd5)    begin n_bad++; $display("FAIL halt_state got %0d exp 5", bus.state); end
    n_vec++; if (bus.halted !== 1'b1)   begin n_bad++; $display("FAIL halt_halted got %b exp 1", bus.halted); end
    n_vec++; if (bus.error !== 1'b0)    begin n_bad++; $display("FAIL halt_error got %b exp 0", bus.error); end
    n_vec++; if (bus.imm !== 4'd6)      begin n_bad++; $display("FAIL halt_imm_hold got %0h exp 6", bus.imm); end
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (bus.state !== 3'd5)  begin n_bad++; $display("FAIL halt_absorb_state[%0d] got %0d exp 5", i, bus.state); end
      n_vec++; if (bus.pc !== 4'd6)     begin n_bad++; $display("FAIL halt_absorb_pc[%0d] got %0h exp 6", i, bus.pc); end
      n_vec++; if ({bus.imem_req, bus.dmem_req, bus.reg_write} !== 3'b000)
        begin n_bad++; $display("FAIL halt_strobes[%0d] got %b exp 000", i, {bus.imem_req, bus.dmem_req, bus.reg_write}); end
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.dmem_ack  = 1'b0;
    bus.alu_zero  = 1'b0;
    test_reset();
    test_addi();
    test_branch();
    test_ldur();
    test_back_to_back();
    test_stur_reset();
    test_timeout();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
